id_hazard_scheduler: RTL and testbench

ID_HAZARD_SCHEDULER -- requirements
Module: id_hazard_scheduler

---
 rtl/id_hazard_scheduler.sv | 143 ++++++++++++++
 tb/tb_id_hazard_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_scheduler.sv
// id_hazard_scheduler: decode-stage RAW/WAW interlock with per-register
// result-latency countdowns.
//
// Ports:
//   Clk, Rst_n          clock, async active-low reset
//   ID_Valid            decode stage holds an instruction
//   ID_Rs, ID_Rt        source register indices
//   ID_Uses_Rs/Rt       source is actually read
//   ID_RegWrite,ID_Dest instruction writes ID_Dest
//   ID_Latency          cycles after issue until result forwardable
//   Flush               kill the decode instruction this cycle
//   ID_Issue            instruction leaves ID this cycle
//   ID_Stall            hold PC and IF/ID
//   Busy_Any            some countdown is nonzero
//   Stall_Count         stall-cycle counter, only with ID_HAZARD_PERF_EN
//
// Optional feature macro: ID_HAZARD_PERF_EN (adds Stall_Count).
module id_hazard_scheduler #(
  parameter int NREG  = 32,
  parameter int LAT_W = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             ID_Valid,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_Uses_Rs,
  input  logic             ID_Uses_Rt,
  input  logic             ID_RegWrite,
  input  logic [4:0]       ID_Dest,
  input  logic [LAT_W-1:0] ID_Latency,
  input  logic             Flush,
  output logic             ID_Issue,
  output logic             ID_Stall,
`ifdef ID_HAZARD_PERF_EN
  output logic             Busy_Any,
  output logic [15:0]      Stall_Count
`else
  output logic             Busy_Any
`endif
);

  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];

  logic [LAT_W-1:0] rs_cnt;
  logic [LAT_W-1:0] rt_cnt;
  logic [LAT_W-1:0] dst_cnt;

  logic raw;
  logic waw;
  logic hazard;
  logic dest_nz;
  logic load;
  logic busy;

  // Indices at or beyond NREG (and register 0) read as idle.
  always_comb begin
    rs_cnt  = '0;
    rt_cnt  = '0;
    dst_cnt = '0;
    for (int r = 1; r < NREG; r++) begin
      if (ID_Rs == 5'(r))
        rs_cnt = cnt_q[r];
      if (ID_Rt == 5'(r))
        rt_cnt = cnt_q[r];
      if (ID_Dest == 5'(r))
        dst_cnt = cnt_q[r];
    end
  end

  assign dest_nz = (ID_Dest != 5'd0);

  // Sources are checked against the pre-update countdowns, so an
  // instruction never hazards against its own destination.
  assign raw = ID_Valid &
               ((ID_Uses_Rs & (rs_cnt != '0)) |
                (ID_Uses_Rt & (rt_cnt != '0)));

  // A younger write may only go once its result would not be
  // overtaken by the older, slower one still in flight.
  assign waw = ID_Valid & ID_RegWrite & dest_nz &
               (dst_cnt > ID_Latency);

  assign hazard = raw | waw;

  assign ID_Stall = Rst_n & ID_Valid & ~Flush & hazard;
  assign ID_Issue = Rst_n & ID_Valid & ~Flush & ~hazard;

  assign load = ID_Issue & ID_RegWrite & dest_nz;

  // Decrement everything; a fresh issue overrides its own register.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      if (cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - 1'b1;
      else
        cnt_d[r] = '0;
      if ((r != 0) && load && (ID_Dest == 5'(r)))
        cnt_d[r] = ID_Latency;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int r = 0; r < NREG; r++)
        cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++)
        cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 0; r < NREG; r++)
      busy = busy | (cnt_q[r] != '0);
  end

  assign Busy_Any = Rst_n & busy;

`ifdef ID_HAZARD_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ID_Stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      stall_cnt_q <= '0;
    else
      stall_cnt_q <= stall_cnt_d;
  end

  assign Stall_Count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_scheduler.sv
// tb_id_hazard_scheduler: directed vector table plus hand sequences
// for id_hazard_scheduler.
module tb_id_hazard_scheduler;

  logic        Clk;
  logic        Rst_n;
  logic        ID_Valid;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_Uses_Rs;
  logic        ID_Uses_Rt;
  logic        ID_RegWrite;
  logic [4:0]  ID_Dest;
  logic [1:0]  ID_Latency;
  logic        Flush;
  logic        ID_Issue;
  logic        ID_Stall;
  logic        Busy_Any;
`ifdef ID_HAZARD_PERF_EN
  logic [15:0] Stall_Count;
`endif

  int errors = 0;
  int checks = 0;

  id_hazard_scheduler #(.NREG(32), .LAT_W(2)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .ID_Valid    (ID_Valid),
    .ID_Rs       (ID_Rs),
    .ID_Rt       (ID_Rt),
    .ID_Uses_Rs  (ID_Uses_Rs),
    .ID_Uses_Rt  (ID_Uses_Rt),
    .ID_RegWrite (ID_RegWrite),
    .ID_Dest     (ID_Dest),
    .ID_Latency  (ID_Latency),
    .Flush       (Flush),
    .ID_Issue    (ID_Issue),
    .ID_Stall    (ID_Stall),
`ifdef ID_HAZARD_PERF_EN
    .Busy_Any    (Busy_Any),
    .Stall_Count (Stall_Count)
`else
    .Busy_Any    (Busy_Any)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       rw;
    logic [4:0] dest;
    logic [1:0] lat;
    logic       fl;
    logic       iss;
    logic       stl;
    logic       busy;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(
    input logic v, input logic [4:0] rs, input logic [4:0] rt,
    input logic urs, input logic urt, input logic rw,
    input logic [4:0] dest, input logic [1:0] lat, input logic fl,
    input logic iss, input logic stl, input logic busy);
    vec_t t;
    t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt;
    t.rw = rw; t.dest = dest; t.lat = lat; t.fl = fl;
    t.iss = iss; t.stl = stl; t.busy = busy;
    return t;
  endfunction

  task automatic check(input string name,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    ID_Valid    = t.v;
    ID_Rs       = t.rs;
    ID_Rt       = t.rt;
    ID_Uses_Rs  = t.urs;
    ID_Uses_Rt  = t.urt;
    ID_RegWrite = t.rw;
    ID_Dest     = t.dest;
    ID_Latency  = t.lat;
    Flush       = t.fl;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge Clk);
      drive(mk(0,0,0,0,0,0,0,0,0,0,0,0));
    end
  endtask

  // Hold a reader of reg src until it issues; return stall cycles seen.
  task automatic wait_issue(input vec_t t, output int stalls,
                            output logic issued);
    stalls = 0;
    issued = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      drive(t);
      #1;
      if (ID_Issue) begin
        issued = 1'b1;
        break;
      end
      if (ID_Stall)
        stalls++;
    end
  endtask

  int   st;
  logic ok;

  initial begin
    //         v rs rt urs urt rw dst lat fl | iss stl busy
    tbl[0]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 1,  8, 1, 0,   1, 0, 0);
    tbl[2]  = mk(1, 8, 0, 1, 0, 0,  0, 0, 0,   0, 1, 1);
    tbl[3]  = mk(1, 8, 0, 1, 0, 0,  0, 0, 0,   1, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 1,  0, 3, 0,   1, 0, 0);
    tbl[5]  = mk(1, 0, 0, 1, 0, 0,  0, 0, 0,   1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 1,  9, 3, 0,   0, 0, 0);
    tbl[7]  = mk(1, 9, 9, 1, 1, 0,  0, 0, 0,   1, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 1, 12, 2, 0,   1, 0, 0);
    tbl[9]  = mk(1,12,12, 0, 1, 0,  0, 0, 0,   0, 1, 1);
    tbl[10] = mk(1,12,12, 0, 0, 0,  0, 0, 0,   1, 0, 1);
    tbl[11] = mk(1, 3, 0, 1, 0, 1,  3, 3, 0,   1, 0, 0);
    tbl[12] = mk(1, 3, 0, 1, 0, 0,  0, 0, 1,   0, 0, 1);
    tbl[13] = mk(1, 0, 0, 0, 0, 1,  7, 3, 1,   0, 0, 1);
    tbl[14] = mk(1, 7, 0, 1, 0, 0,  0, 0, 0,   1, 0, 1);
    tbl[15] = mk(1, 3, 0, 1, 0, 0,  0, 0, 0,   1, 0, 0);
    tbl[16] = mk(1, 0, 0, 0, 0, 1, 10, 2, 0,   1, 0, 0);
    tbl[17] = mk(1, 0, 0, 0, 0, 1, 10, 1, 0,   0, 1, 1);
    tbl[18] = mk(1, 0, 0, 0, 0, 1, 10, 1, 0,   1, 0, 1);
    tbl[19] = mk(1,10, 0, 1, 0, 0,  0, 0, 0,   0, 1, 1);
    tbl[20] = mk(1,10, 0, 1, 0, 0,  0, 0, 0,   1, 0, 0);
    tbl[21] = mk(1, 0, 0, 0, 0, 1,  4, 3, 0,   1, 0, 0);
    tbl[22] = mk(0, 4, 0, 1, 0, 0,  0, 0, 0,   0, 0, 1);

    // Reset held with a valid instruction presented.
    Rst_n = 1'b0;
    drive(mk(1,0,0,0,0,1,5,3,0,0,0,0));
    #2;
    check("rst.issue", 16'(ID_Issue), 16'd0);
    check("rst.stall", 16'(ID_Stall), 16'd0);
    check("rst.busy",  16'(Busy_Any), 16'd0);
    @(negedge Clk);
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0));
    @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      @(negedge Clk);
      drive(tbl[i]);
      #1;
      check($sformatf("row%0d.issue", i), 16'(ID_Issue), 16'(tbl[i].iss));
      check($sformatf("row%0d.stall", i), 16'(ID_Stall), 16'(tbl[i].stl));
      check($sformatf("row%0d.busy", i),  16'(Busy_Any), 16'(tbl[i].busy));
    end

    // WAW: older write Lat=3, a bubble, then younger Lat=0 write.
    idle(4);
    #1;
    check("waw.pre_busy", 16'(Busy_Any), 16'd0);
    @(negedge Clk);
    drive(mk(1,0,0,0,0,1,5,3,0,0,0,0));
    #1;
    check("waw.first_issue", 16'(ID_Issue), 16'd1);
    idle(1);
    wait_issue(mk(1,0,0,0,0,1,5,0,0,0,0,0), st, ok);
    check("waw.issued", 16'(ok), 16'd1);
    check("waw.stalls", 16'(st), 16'd2);
    idle(1);
    #1;
    check("waw.cnt5_zero", 16'(Busy_Any), 16'd0);
    @(negedge Clk);
    drive(mk(1,5,0,1,0,0,0,0,0,0,0,0));
    #1;
    check("waw.read5_issue", 16'(ID_Issue), 16'd1);

    // Async reset in the middle of a stall.
    idle(4);
    @(negedge Clk);
    drive(mk(1,0,0,0,0,1,6,3,0,0,0,0));
    @(negedge Clk);
    drive(mk(1,6,0,1,0,0,0,0,0,0,0,0));
    #1;
    check("arst.pre_stall", 16'(ID_Stall), 16'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    check("arst.stall", 16'(ID_Stall), 16'd0);
    check("arst.issue", 16'(ID_Issue), 16'd0);
    check("arst.busy",  16'(Busy_Any), 16'd0);
    @(negedge Clk);
    #1;
    check("arst.hold_stall", 16'(ID_Stall), 16'd0);
    Rst_n = 1'b1;
    #1;
    check("arst.rel_busy",  16'(Busy_Any), 16'd0);
    check("arst.rel_stall", 16'(ID_Stall), 16'd0);
    check("arst.rel_issue", 16'(ID_Issue), 16'd1);

`ifdef ID_HAZARD_PERF_EN
    check("perf.after_rst", Stall_Count, 16'd0);
    idle(1);
    @(negedge Clk);
    drive(mk(1,0,0,0,0,1,11,3,0,0,0,0));
    wait_issue(mk(1,11,0,1,0,0,0,0,0,0,0,0), st, ok);
    idle(1);
    #1;
    check("perf.count3", Stall_Count, 16'd3);
    @(negedge Clk);
    dut.stall_cnt_q = 16'hFFFE;
    drive(mk(1,0,0,0,0,1,11,3,0,0,0,0));
    wait_issue(mk(1,11,0,1,0,0,0,0,0,0,0,0), st, ok);
    idle(1);
    #1;
    check("perf.saturate", Stall_Count, 16'hFFFF);
`endif

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
